// File: rtl/spi_flash_rd_arb.sv
// Two-requester round-robin SPI flash byte reader (mode 0, READ 0x03).
// Define SPI_FAST_READ_EN to issue FAST_READ 0x0B with 8 dummy clocks instead.
module spi_flash_rd_arb #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_IDLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [23:0] addr0,
  output logic        done0,
  input  logic        req1,
  input  logic [23:0] addr1,
  output logic        done1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        spi_csb,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDLE_W = $clog2(CS_IDLE + 1);
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0]  CMD   = 8'h0B;
  localparam int unsigned NBITS = 48;
`else
  localparam logic [7:0]  CMD   = 8'h03;
  localparam int unsigned NBITS = 40;
`endif
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]        BIT_LAST  = 6'(NBITS);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(CS_IDLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SHIFT,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        sr;
  logic [7:0]         rx;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         bit_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               last_grant;
  logic               gid;
  logic               win_c;

  // Round-robin: a lone requester wins; on contention the one not served last.
  assign win_c = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sr         <= '0;
      rx         <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      last_grant <= 1'b1;
      gid        <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      spi_csb    <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (idle_cnt != '0) idle_cnt <= idle_cnt - IDLE_W'(1);

      unique case (state)
        S_IDLE: begin
          if (idle_cnt == '0 && (req0 || req1)) begin
            gid        <= win_c;
            last_grant <= win_c;
            sr         <= {CMD, win_c ? addr1 : addr0};
            busy       <= 1'b1;
            state      <= S_GRANT;
          end
        end

        S_GRANT: begin
          spi_csb  <= 1'b0;
          spi_mosi <= sr[31];
          div_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= S_SHIFT;
        end

        // Low half first; sample MISO on rise, advance MOSI on fall.
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              rx      <= {rx[6:0], spi_miso};
              bit_cnt <= bit_cnt + 6'd1;
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                spi_mosi <= 1'b0;
                state    <= S_CS_HOLD;
              end else begin
                spi_mosi <= sr[30];
                sr       <= {sr[30:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_CS_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            spi_csb  <= 1'b1;
            idle_cnt <= IDLE_LOAD;
            rdata    <= rx;
            done0    <= ~gid;
            done1    <= gid;
            state    <= S_DONE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd_arb.sv
// Bench for spi_flash_rd_arb: SPI flash model, transaction-level reference model and directed tests.
module tb_spi_flash_rd_arb;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_IDLE = 4;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD        = 8'h0B;
  localparam int         NB         = 48;
  localparam int         LAT_LIT    = 196;
  localparam int         DATA_START = 40;
`else
  localparam logic [7:0] CMD        = 8'h03;
  localparam int         NB         = 40;
  localparam int         LAT_LIT    = 164;
  localparam int         DATA_START = 32;
`endif
  localparam int LAT = 1 + 2 * NB * CLK_DIV + CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [23:0] addr0, addr1;
  logic        done0, done1, busy;
  logic [7:0]  rdata;
  logic        spi_csb, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  int tests = 0;
  int fails = 0;

  spi_flash_rd_arb #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .done0(done0),
    .req1(req1), .addr1(addr1), .done1(done1),
    .rdata(rdata), .busy(busy),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a == 24'h000100) return 8'hA5;
    if (a == 24'h00FFFE) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Flash model: shifts in command+address on SCK rise, drives data on SCK fall
  int          fl_rise = 0;
  int          fl_rises = 0;
  logic [31:0] fl_in = '0;
  logic [31:0] fl_word = '0;
  logic [7:0]  fl_sh = '0;

  always @(posedge spi_sck or negedge spi_csb or posedge spi_csb) begin
    if (spi_csb) begin
      fl_rises = fl_rise;
      fl_word  = fl_in;
    end else if (spi_sck) begin
      fl_rise++;
      if (fl_rise <= 32) fl_in = {fl_in[30:0], spi_mosi};
    end else begin
      fl_rise = 0;
      fl_in   = '0;
    end
  end

  always @(negedge spi_sck) begin
    if (fl_rise == DATA_START) begin
      fl_sh    = mem_byte(fl_in[23:0]);
      spi_miso = fl_sh[7];
      fl_sh    = {fl_sh[6:0], 1'b0};
    end else if (fl_rise > DATA_START) begin
      spi_miso = fl_sh[7];
      fl_sh    = {fl_sh[6:0], 1'b0};
    end
  end

  int dc0 = 0;
  int dc1 = 0;
  always @(negedge clk) begin
    if (done0) dc0++;
    if (done1) dc1++;
  end

  // Literal expectations posted by the stimulus, checked by the compare process
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;
  lit_t lit_q[$];
  int   lit_rd = 0;

  task automatic expect_lit(input string n, input logic [31:0] a, input logic [31:0] e);
    lit_t l;
    l.name = n; l.act = a; l.exp = e;
    lit_q.push_back(l);
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: expected pin waveform as a function of cycle offset since grant
  bit          act = 1'b0;
  int          t = 0;
  int          gap = 0;
  logic        last_m = 1'b1;
  logic        gid_m = 1'b0;
  logic        win;
  logic [31:0] word = '0;
  logic [7:0]  rdata_m = '0;
  logic        p_req0 = 1'b0, p_req1 = 1'b0;
  logic [23:0] p_addr0 = '0, p_addr1 = '0;

  always @(negedge clk) begin
    while (lit_rd < lit_q.size()) begin
      chk(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
      lit_rd++;
    end
    if (rst) begin
      chk("rst_csb", 32'(spi_csb), 32'd1);
      chk("rst_sck", 32'(spi_sck), 32'd0);
      chk("rst_mosi", 32'(spi_mosi), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'({done1, done0}), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      act = 1'b0; last_m = 1'b1; rdata_m = '0; gap = CS_IDLE;
    end else begin
      if (!act && busy) begin
        chk("grant_has_req", 32'(p_req0 | p_req1), 32'd1);
        win    = (p_req0 && p_req1) ? ~last_m : p_req1;
        act    = 1'b1;
        t      = 0;
        gid_m  = win;
        last_m = win;
        word   = {CMD, win ? p_addr1 : p_addr0};
      end
      if (act) begin
        logic e_sck, e_mosi, e_csb;
        int   k;
        e_csb  = !(t >= 1 && t <= LAT - 2);
        e_sck  = 1'b0;
        e_mosi = 1'b0;
        if (t >= 1 && t < 1 + 2 * NB * CLK_DIV) begin
          e_sck = ((t - 1) / CLK_DIV) % 2 == 1;
          k     = (t - 1) / (2 * CLK_DIV);
          if (k < 32) e_mosi = word[31 - k];
        end
        if (t == LAT - 1) rdata_m = mem_byte(word[23:0]);
        chk("csb", 32'(spi_csb), 32'(e_csb));
        chk("sck", 32'(spi_sck), 32'(e_sck));
        chk("mosi", 32'(spi_mosi), 32'(e_mosi));
        chk("busy", 32'(busy), 32'd1);
        chk("done0", 32'(done0), 32'(t == LAT - 1 && gid_m == 1'b0));
        chk("done1", 32'(done1), 32'(t == LAT - 1 && gid_m == 1'b1));
        chk("rdata", 32'(rdata), 32'(rdata_m));
        if (t == 1) chk("cs_gap", 32'(gap >= CS_IDLE), 32'd1);
        if (t == LAT - 1) act = 1'b0;
        else t++;
      end else begin
        chk("idle_csb", 32'(spi_csb), 32'd1);
        chk("idle_sck", 32'(spi_sck), 32'd0);
        chk("idle_done", 32'({done1, done0}), 32'd0);
        chk("idle_rdata", 32'(rdata), 32'(rdata_m));
      end
      gap = spi_csb ? gap + 1 : 0;
    end
    p_req0 = req0; p_req1 = req1; p_addr0 = addr0; p_addr1 = addr1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int who, output int len);
    bit seen;
    seen = 1'b0; who = -1; len = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk); #1;
      if (busy) len++;
      if (done0 || done1) begin
        seen = 1'b1;
        who  = done1 ? 1 : 0;
      end
    end
    expect_lit("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int who, len, d0, d1;
    int order[4];
    rst = 1'b1; req0 = 1'b1; req1 = 1'b0; addr0 = 24'h000100; addr1 = 24'h00FFFE;
    tick(3);
    expect_lit("rst_hold_csb", 32'(spi_csb), 32'd1);
    expect_lit("rst_hold_busy", 32'(busy), 32'd0);
    expect_lit("rst_hold_done0", 32'(done0), 32'd0);
    req0 = 1'b0; rst = 1'b0;
    tick(2);

    // Contention from reset: requester 0 first, then 1
    req0 = 1'b1; req1 = 1'b1;
    wait_done(who, len);
    expect_lit("cont_first", 32'(who), 32'd0);
    expect_lit("cont_rdata0", 32'(rdata), 32'hA5);
    req0 = 1'b0;
    wait_done(who, len);
    expect_lit("cont_second", 32'(who), 32'd1);
    expect_lit("cont_rdata1", 32'(rdata), 32'h3C);
    expect_lit("cont_word1", fl_word, {CMD, 24'h00FFFE});
    req1 = 1'b0;
    tick(10);

    // Single read by requester 0
    d1 = dc1;
    req0 = 1'b1; addr0 = 24'h000100;
    wait_done(who, len);
    expect_lit("single_who", 32'(who), 32'd0);
    expect_lit("single_lat", 32'(len), 32'(LAT_LIT));
    expect_lit("single_rdata", 32'(rdata), 32'hA5);
    expect_lit("single_word", fl_word, {CMD, 24'h000100});
    expect_lit("single_rises", 32'(fl_rises), 32'(NB));
    req0 = 1'b0;
    tick(2);
    expect_lit("single_no_done1", 32'(dc1), 32'(d1));
    tick(8);

    // Requester 1 at 0x123456
    req1 = 1'b1; addr1 = 24'h123456;
    wait_done(who, len);
    expect_lit("r1_who", 32'(who), 32'd1);
    expect_lit("r1_lat", 32'(len), 32'(LAT_LIT));
    expect_lit("r1_word", fl_word, {CMD, 24'h123456});
    expect_lit("r1_rises", 32'(fl_rises), 32'(NB));
    expect_lit("r1_rdata", 32'(rdata), 32'h2A);
    req1 = 1'b0;
    tick(10);

    // Fairness: both held for four transactions
    addr0 = 24'h000010; addr1 = 24'h000020;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) wait_done(order[i], len);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) expect_lit($sformatf("fair_%0d", i), 32'(order[i]), 32'(i % 2));
    tick(10);

    // Reset after 20 SCK rises, then a clean restart
    req0 = 1'b1; addr0 = 24'h000100;
    for (int i = 0; i < 1000 && fl_rise < 20; i++) tick(1);
    expect_lit("mid_reach20", 32'(fl_rise >= 20), 32'd1);
    rst = 1'b1;
    #1;
    expect_lit("mid_csb", 32'(spi_csb), 32'd1);
    expect_lit("mid_sck", 32'(spi_sck), 32'd0);
    expect_lit("mid_busy", 32'(busy), 32'd0);
    d0 = dc0;
    tick(3);
    rst = 1'b0;
    wait_done(who, len);
    expect_lit("mid_who", 32'(who), 32'd0);
    expect_lit("mid_lat", 32'(len), 32'(LAT_LIT));
    expect_lit("mid_rdata", 32'(rdata), 32'hA5);
    expect_lit("mid_word", fl_word, {CMD, 24'h000100});
    expect_lit("mid_rises", 32'(fl_rises), 32'(NB));
    req0 = 1'b0;
    tick(1);
    expect_lit("mid_one_done", 32'(dc0), 32'(d0 + 1));
    tick(10);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_flash_rd_arb.md
Name: spi_flash_rd_arb

Overview:
- Read-only SPI flash master that shares the single external flash between two internal requesters.
- Typical requesters: requester 0 = exposure/aperture lookup tables, requester 1 = display/config constants.
- Arbitrates round-robin, issues single-byte READ (0x03) transactions in SPI mode 0 on the flash pins, and returns the byte to the granted requester.
- Sits between the UI/exposure logic and the top-level uio/ui pin mapping (CSB, SCK, MOSI out; MISO in).

Parameters:
- CLK_DIV, 2, SCK half-period in clk cycles (>=1); SCK period = 2*CLK_DIV clk cycles.
- CS_IDLE, 4, minimum clk cycles CSB stays high between transactions (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0  in  1  requester 0 read request, level, held until done0
- addr0  in  24  requester 0 byte address, sampled at grant
- done0  out  1  one-cycle pulse, rdata valid for requester 0
- req1  in  1  requester 1 read request, level, held until done1
- addr1  in  24  requester 1 byte address, sampled at grant
- done1  out  1  one-cycle pulse, rdata valid for requester 1
- rdata  out  8  last byte read; stable until next done pulse
- busy  out  1  high from grant until done pulse inclusive
- spi_csb  out  1  flash chip select, active low
- spi_sck  out  1  flash clock, idles low (mode 0)
- spi_mosi  out  1  flash data in
- spi_miso  in  1  flash data out; treated as synchronous to SCK, no synchroniser

Behaviour:
- Reset values: spi_csb=1, spi_sck=0, spi_mosi=0, done0=done1=0, busy=0, rdata=0x00, last_grant=1 (so req0 wins first contention), CS-idle counter preloaded to 0 (first transaction not delayed).
- States: IDLE -> GRANT -> SHIFT -> CS_HOLD -> DONE -> IDLE.
- IDLE: when CS-idle counter expired and any req high, choose winner:
  - only one requesting -> that one;
  - both requesting -> the one != last_grant.
  - Go to GRANT.
- GRANT (1 cycle):
  - Latch shift register = {cmd 0x03, addrN}; busy=1; last_grant=N.
  - spi_csb falls at end of cycle; spi_mosi = bit 31 of shift register.
- SHIFT: 40 SCK periods (8 cmd + 24 addr + 8 data), MSB first.
  - SCK high for CLK_DIV cycles, low for CLK_DIV cycles; first rising edge CLK_DIV cycles after CSB falls.
  - On each SCK rising edge sample spi_miso into data shift register.
  - On each falling edge advance MOSI to the next bit.
  - During the 8 data bits MOSI=0.
  - 6-bit bit counter, terminal at 40 rising edges.
- CS_HOLD: after the 40th falling edge, SCK low; hold CSB low CLK_DIV more cycles, then CSB=1; load CS-idle counter with CS_IDLE.
- DONE (1 cycle): rdata <= captured byte; doneN=1 for the granted requester only; busy=1 this cycle, 0 next.
- Total latency, grant to done: 1 + 40*2*CLK_DIV + CLK_DIV + 1 cycles (164 with CLK_DIV=2).
- Request rules:
  - Requests are not re-evaluated mid-transaction; a newly raised request waits.
  - Dropping reqN after grant does not abort; doneN still pulses.
  - A requester that keeps req high after done is re-arbitrated normally. With both held high, grants strictly alternate 0,1,0,1.
- Async rst mid-transaction: immediately spi_csb=1, spi_sck=0, no done pulse; the transaction is lost and the requester must keep or re-raise req.
- Address changes after grant are ignored.

Optional Feature:
- SPI_FAST_READ_EN:
  - Defined: command byte 0x0B and 8 dummy SCK periods (MOSI=0, MISO ignored) inserted between address and data. 48 SCK periods total; latency with CLK_DIV=2 becomes 196 cycles.
  - Undefined: plain READ 0x03, 40 periods as above.

Test Plan:
- Reset: assert rst with req0=1 -> spi_csb=1, spi_sck=0, done0=done1=0, busy=0, rdata=0x00 while rst high.
- Single read: req0=1, addr0=0x000100, flash model returns 0xA5 -> MOSI stream 0x03,0x00,0x01,0x00; exactly 40 SCK rising edges; rdata=0xA5 with a done0 pulse 164 cycles after grant; done1 stays 0.
- Contention: req0 and req1 rise on the same cycle (addr1=0x00FFFE, data 0x3C) -> requester 0 served first; then CSB high >=4 cycles; then requester 1 with done1 and rdata=0x3C.
- Fairness: req0 and req1 held high for 4 transactions -> grant order 0,1,0,1; CSB high gaps of >=CS_IDLE cycles each.
- Reset mid-operation: rst pulse after 20 SCK edges -> CSB high and SCK low within the same cycle; no done pulse; with req0 still high, a fresh full 0x03 transaction restarts after rst release.
- SPI_FAST_READ_EN build: req1, addr1=0x123456 -> MOSI 0x0B,0x12,0x34,0x56 then 8 dummy clocks; 48 SCK edges; done1 at 196 cycles.
